// File: rtl/dct_block_loader.sv
// dct_block_loader
// Collects a raster-ordered pixel stream into the packed 8x8 operand A of the
// DCT matrix multiplier. Once 64 pixels are in, it raises Enable and holds A
// until the multiplier reports done. It then waits for done to drop before
// accepting the next block.
//
// state   | meaning
// --------+------------------------------------------------------------
// FILL    | accepting pixels, writing element[count], Enable low
// RUN     | block complete, Enable high, A frozen, waiting for done
// RELEASE | Enable low, A frozen, waiting for done to return low
module dct_block_loader #(
  parameter int N      = 8,
  parameter int PIX_W  = 8,
  parameter int ELEM_W = 16
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    level_shift,
  output logic [N*N*ELEM_W-1:0]   A,
  output logic                    Enable,
  input  logic                    done,
  output logic                    busy
);

  localparam int NUM   = N * N;
  localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM - 1);
  localparam logic [PIX_W-1:0] PIX_MSB  = PIX_W'(1) << (PIX_W - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NUM*ELEM_W-1:0]   a_q, a_d;
  logic                    ready_q, ready_d;

  logic                    xfer;
  logic [PIX_W-1:0]        pix_off;
  logic [ELEM_W-1:0]       elem;

  // A transfer only happens while pix_ready is visible to the upstream stage.
  assign xfer = pix_valid && ready_q;

  // Element formatting: flipping the MSB of an unsigned pixel gives pix-128
  // in two's complement, which is then sign-extended; otherwise zero-extend.
  always_comb begin
    pix_off = pix_in ^ PIX_MSB;
    if (level_shift) begin
      elem = {{(ELEM_W-PIX_W){pix_off[PIX_W-1]}}, pix_off};
    end else begin
      elem = {{(ELEM_W-PIX_W){1'b0}}, pix_in};
    end
  end

  // Next-state logic: packing in FILL, handshake with the multiplier otherwise.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    case (state_q)
      FILL: begin
        if (xfer) begin
          a_d[int'(count_q)*ELEM_W +: ELEM_W] = elem;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = RUN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (done) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!done) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    // Registered so pix_ready stays low through the reset cycle itself.
    ready_d = (state_d == FILL);
  end

  // State, counter, operand and ready registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      a_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      ready_q <= ready_d;
    end
  end

  assign pix_ready = ready_q;
  assign A         = a_q;
  assign Enable    = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == RELEASE);

endmodule
